// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state type, command-format constants and
// the status-byte builder for the SPI configuration register file.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  localparam int CMD_WR_BIT   = 7;
  localparam int ADDR_W       = 7;
  localparam int STAT_ERR_BIT = 0;

  function automatic logic [7:0] status_byte(input logic err);
    logic [7:0] s;
    s = '0;
    s[STAT_ERR_BIT] = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_cfg_regfile_sync_2ff.sv
// sync_2ff: two-flop synchronizer with configurable reset value.
// Ports: CLK, RESET (async, high), d (async in), q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/spi_cfg_regfile.sv
// spi_cfg_regfile: SPI command decoder + 8-bit config register bank.
// In: CLK, RESET, SS, data_valid, received_data.
// Out: data_to_send, cfg_regs, wr_strobe/wr_addr/wr_data,
//      addr_err, frame_active.
// Option: SPI_CFG_AUTOINC_EN enables pointer auto-increment.
module spi_cfg_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 7
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SS,
  input  logic                  data_valid,
  input  logic [7:0]            received_data,
  output logic [7:0]            data_to_send,
  output logic [NUM_REGS*8-1:0] cfg_regs,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  addr_err,
  output logic                  frame_active
);

  import spi_cfg_pkg::*;

  logic dv_s, dv_d, ss_s, ss_d;
  logic byte_stb, ss_rise, accept;
  logic skip;
  logic [1:0] hold;

  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, ptr_nxt;
  logic [ADDR_W-1:0] cmd_addr, wr_addr_n;
  logic [7:0] dts_n, wr_data_n, rd_cmd, rd_nxt;
  logic err_n, stb_n, we;
  logic cmd_ok, ptr_ok;

  sync_2ff #(.RST_VAL(1'b0)) u_dv_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (data_valid),
    .q     (dv_s)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (SS),
    .q     (ss_s)
  );

  assign byte_stb     = dv_s & ~dv_d;
  assign ss_rise      = ss_s & ~ss_d;
  assign frame_active = ~ss_s;

  // A byte completing together with SS release still belongs to
  // the frame. After a mid-frame reset the rest of the frame is
  // skipped until SS is seen high again.
  assign accept = byte_stb & (~ss_s | ss_rise) & ~skip;

  assign cmd_addr = received_data[ADDR_W-1:0];
  assign cmd_ok   = 32'(cmd_addr) < NUM_REGS;
  assign ptr_ok   = 32'(ptr) < NUM_REGS;

`ifdef SPI_CFG_AUTOINC_EN
  assign ptr_nxt = !ptr_ok ? ptr :
                   (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 :
                   ptr + ADDR_W'(1);
`else
  assign ptr_nxt = ptr;
`endif

  // Out-of-range addresses fall through to 0x00.
  always_comb begin
    rd_cmd = '0;
    rd_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) rd_cmd = cfg_regs[i*8 +: 8];
      if (ptr_nxt == ADDR_W'(i))  rd_nxt = cfg_regs[i*8 +: 8];
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    dts_n     = data_to_send;
    err_n     = addr_err;
    stb_n     = 1'b0;
    we        = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    if (accept) begin
      unique case (state)
        IDLE: begin
          ptr_n = cmd_addr;
          err_n = ~cmd_ok;
          if (received_data[CMD_WR_BIT]) begin
            state_n = WR_DATA;
            dts_n   = status_byte(err_n);
          end else begin
            state_n = RD_DATA;
            dts_n   = cmd_ok ? rd_cmd : 8'h00;
          end
        end
        WR_DATA: begin
          if (ptr_ok) begin
            we        = 1'b1;
            stb_n     = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = received_data;
          end
          ptr_n = ptr_nxt;
        end
        RD_DATA: begin
          ptr_n = ptr_nxt;
          dts_n = rd_nxt;
        end
        default: state_n = IDLE;
      endcase
    end
    if (ss_rise) begin
      state_n = IDLE;
      dts_n   = status_byte(err_n);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dv_d         <= 1'b0;
      ss_d         <= 1'b1;
      skip         <= 1'b1;
      hold         <= 2'd0;
      state        <= IDLE;
      ptr          <= '0;
      data_to_send <= 8'h00;
      addr_err     <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
      cfg_regs     <= '0;
    end else begin
      dv_d         <= dv_s;
      ss_d         <= ss_s;
      if (hold != 2'd2) hold <= hold + 2'd1;
      // hold==2: synchronizer now reflects the real SS level
      if (ss_rise || (hold == 2'd2 && ss_s)) skip <= 1'b0;
      state        <= state_n;
      ptr          <= ptr_n;
      data_to_send <= dts_n;
      addr_err     <= err_n;
      wr_strobe    <= stb_n;
      wr_addr      <= wr_addr_n;
      wr_data      <= wr_data_n;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && ptr == ADDR_W'(i)) begin
          cfg_regs[i*8 +: 8] <= received_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// tb_spi_cfg_regfile: directed bench for spi_cfg_regfile
// (NUM_REGS=16), expectations follow SPI_CFG_AUTOINC_EN if set.
module tb_spi_cfg_regfile;

  localparam int NR = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          SS;
  logic          data_valid;
  logic [7:0]    received_data;
  logic [7:0]    data_to_send;
  logic [NR*8-1:0] cfg_regs;
  logic          wr_strobe;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          addr_err;
  logic          frame_active;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic [NR*8-1:0] exp_cfg = '0;

  spi_cfg_regfile #(.NUM_REGS(NR), .ADDR_W(7)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .SS            (SS),
    .data_valid    (data_valid),
    .received_data (received_data),
    .data_to_send  (data_to_send),
    .cfg_regs      (cfg_regs),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .addr_err      (addr_err),
    .frame_active  (frame_active)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (wr_strobe === 1'b1) begin
      stb_cnt   <= stb_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [NR*8-1:0] obs,
                     input logic [NR*8-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    received_data = b;
    data_valid = 1'b1;
    cyc(4);
    data_valid = 1'b0;
    cyc(4);
  endtask

  task automatic frame_start();
    SS = 1'b0;
    cyc(3);
  endtask

  task automatic frame_end();
    SS = 1'b1;
    cyc(6);
  endtask

  task automatic set_exp(input int idx, input logic [7:0] v);
    exp_cfg[idx*8 +: 8] = v;
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    SS = 1'b1;
    data_valid = 1'b0;
    received_data = 8'h00;
    cyc(3);
    chk("rst_dts", data_to_send, 0);
    chk("rst_cfg", cfg_regs, 0);
    chk("rst_stb", wr_strobe, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_fa", frame_active, 0);
    RESET = 1'b0;
    cyc(6);

    // single write
    stb_cnt = 0;
    frame_start();
    chk("fa_on", frame_active, 1);
    send_byte(8'h83);
    send_byte(8'h5A);
    frame_end();
    set_exp(3, 8'h5A);
    chk("wr_stb_cnt", stb_cnt, 1);
    chk("wr_addr", last_addr, 3);
    chk("wr_data", last_data, 8'h5A);
    chk("wr_cfg", cfg_regs, exp_cfg);
    chk("wr_reg3", cfg_regs[31:24], 8'h5A);
    chk("wr_err", addr_err, 0);
    chk("fa_off", frame_active, 0);

    // read back with latency bound
    frame_start();
    received_data = 8'h03;
    data_valid = 1'b1;
    n = 0;
    while (n < 3 && data_to_send !== 8'h5A) begin
      cyc(1);
      n++;
    end
    chk("rd_lat", data_to_send, 8'h5A);
    cyc(1);
    data_valid = 1'b0;
    cyc(4);
    send_byte(8'h00);
`ifdef SPI_CFG_AUTOINC_EN
    chk("rd_data", data_to_send, 8'h00);
`else
    chk("rd_data", data_to_send, 8'h5A);
`endif
    frame_end();
    chk("rd_status", data_to_send, 8'h00);

    // burst write at top of bank
    stb_cnt = 0;
    frame_start();
    send_byte(8'h8F);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_end();
`ifdef SPI_CFG_AUTOINC_EN
    set_exp(15, 8'h11);
    set_exp(0, 8'h22);
`else
    set_exp(15, 8'h22);
`endif
    chk("burst_cnt", stb_cnt, 2);
    chk("burst_cfg", cfg_regs, exp_cfg);

    // out-of-range write
    stb_cnt = 0;
    frame_start();
    send_byte(8'hC0);
    chk("oor_err_mid", addr_err, 1);
    send_byte(8'hFF);
    frame_end();
    chk("oor_cnt", stb_cnt, 0);
    chk("oor_cfg", cfg_regs, exp_cfg);
    chk("oor_err", addr_err, 1);
    chk("oor_status", data_to_send, 8'h01);

    // in-range command clears the flag
    frame_start();
    send_byte(8'h01);
    chk("clr_err", addr_err, 0);
    send_byte(8'h00);
    frame_end();
    chk("clr_status", data_to_send, 8'h00);

    // reset after a write command byte
    stb_cnt = 0;
    frame_start();
    send_byte(8'h84);
    RESET = 1'b1;
    cyc(1);
    exp_cfg = '0;
    chk("mrst_cfg", cfg_regs, exp_cfg);
    chk("mrst_dts", data_to_send, 0);
    chk("mrst_err", addr_err, 0);
    RESET = 1'b0;
    cyc(3);
    send_byte(8'h77);
    chk("mrst_cnt", stb_cnt, 0);
    chk("mrst_nowr", cfg_regs, exp_cfg);
    frame_end();
    frame_start();
    send_byte(8'h84);
    send_byte(8'h66);
    frame_end();
    set_exp(4, 8'h66);
    chk("mrst_next_cnt", stb_cnt, 1);
    chk("mrst_next_cfg", cfg_regs, exp_cfg);

    // data byte and SS release together
    stb_cnt = 0;
    frame_start();
    send_byte(8'h82);
    received_data = 8'h99;
    data_valid = 1'b1;
    SS = 1'b1;
    cyc(6);
    data_valid = 1'b0;
    cyc(4);
    set_exp(2, 8'h99);
    chk("sim_cnt", stb_cnt, 1);
    chk("sim_cfg", cfg_regs, exp_cfg);
    chk("sim_status", data_to_send, 8'h00);
    frame_start();
    send_byte(8'h02);
    chk("sim_idle_rd", data_to_send, 8'h99);
    frame_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
